spi_burst_ctrl: RTL and testbench
=================================

Name: spi_burst_ctrl

Overview:
Transaction sequencer that sits between a host-side streaming interface and the byte-wide SPI master.
- Accepts a burst command of 1..16 bytes with mode and baud configuration, then drives the master's configuration, data and slave-select inputs.
- Runs one master byte transfer per TX byte and streams each received byte out through a valid/ready port.
- Deasserts slave-select between bytes so the master reloads its shift register, and aborts on a finish timeout.

Parameters:
GAP_CYC, 4, clk cycles m_spssn is held high before each byte (legal range >= 2)
TIMEOUT, 4096, max clk cycles in XFER waiting for m_finish before the burst is aborted

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
cmd_valid  in  1  burst command valid
cmd_ready  out  1  controller can accept a command
cmd_len  in  4  number of bytes minus 1 (0 = 1 byte, 15 = 16 bytes)
cmd_cpol  in  1  SCK idle polarity for the burst
cmd_cpha  in  1  SCK phase for the burst
cmd_br  in  8  baud-rate register value for the burst
tx_valid / tx_ready / tx_data  in / out / in  1/1/8  TX byte stream
rx_valid / rx_ready / rx_data  out / in / out  1/1/8  RX byte stream
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst end
err  out  1  last burst aborted by timeout; sticky until next cmd accept
m_data  out  8  byte to master
m_spcon  out  8  master control: bit6 enable, bits[2:1] {cpol,cpha}, other bits 0
m_spibr  out  8  master baud register
m_spssn  out  1  master slave-select, active-low
m_data_r  in  8  master received byte
m_finish  in  1  master one-cycle byte-complete pulse

Behaviour:
- Reset values:
  - state IDLE, cmd_ready=1.
  - tx_ready=0, rx_valid=0, rx_data=0x00, busy=0, done=0, err=0.
  - m_data=0x00, m_spcon=0x00, m_spibr=0x00, m_spssn=1.
- Combinational decodes: cmd_ready = (state==IDLE); tx_ready = (state==FETCH). All other outputs are registered.
- IDLE:
  - On cmd_valid, latch len into remaining, set m_spibr=cmd_br, m_spcon={1'b0,1'b1,3'b000,cmd_cpol,cmd_cpha,1'b0}.
  - Also set busy=1, clear err, go FETCH.
  - While not IDLE, cmd_valid is ignored.
- FETCH:
  - m_spssn=1.
  - On tx_valid&&tx_ready, m_data<=tx_data, gap counter<=GAP_CYC, go SETUP.
  - TX starvation holds FETCH indefinitely.
- SETUP:
  - m_spssn=1; decrement gap counter each cycle.
  - After GAP_CYC cycles, m_spssn<=0, timeout counter<=0, go XFER.
  - m_spssn falls exactly GAP_CYC+1 cycles after the TX handshake.
- XFER:
  - m_spssn=0, m_data stable.
  - On m_finish: rx_data<=m_data_r, rx_valid<=1, m_spssn<=1, go RXWAIT.
  - If the timeout counter reaches TIMEOUT-1 without m_finish: m_spssn<=1, err<=1, go DONE; no RX byte for the aborted transfer, remaining bytes dropped.
- RXWAIT:
  - Hold rx_valid and rx_data until rx_ready.
  - On handshake, rx_valid<=0.
  - If remaining==0 go DONE; else remaining<=remaining-1 and go FETCH.
  - rx_ready asserted in the same cycle rx_valid rises is accepted on the next edge (rx_valid is high for at least 1 cycle).
- DONE:
  - done=1 for one cycle, m_spcon[6]<=0, busy<=0, go IDLE.
  - m_spcon[2:1] and m_spibr keep the burst values until the next command so SCK idle level stays stable.
- m_spssn is never low outside XFER; m_data never changes while m_spssn=0.
- m_finish outside XFER is ignored.
- rst_n asserted mid-burst: all outputs return to reset values immediately; partial data is discarded; no done pulse.

Test Plan:
- len=0, tx 0xA5, cpol=0 cpha=0, br=0x00, real master with miso looped to mosi -> one m_spssn low window, rx_data=0xA5, done one pulse, err=0, cmd_ready=1 the cycle after done.
- len=3, tx 0x01,0x02,0x03,0x04, cpol=1 cpha=1, br=0x12, loopback -> rx 0x01..0x04 in order; four m_spssn low windows, each preceded by >=GAP_CYC high cycles; m_spcon=0x46 throughout busy.
- Same burst, rx_ready low for 20 cycles after first rx_valid -> rx_data 0x01 held stable, m_spssn stays high, no second XFER until the handshake.
- len=1, second tx_valid delayed 30 cycles -> FETCH held, m_spssn=1, busy=1; burst completes normally after tx arrives.
- TIMEOUT=64, master model never pulses m_finish -> m_spssn rises 64 cycles after falling, done pulse with err=1, rx_valid never asserted.
- rst_n pulsed low during XFER of byte 2 of a 4-byte burst -> m_spssn=1, m_spcon=0x00, busy=0, cmd_ready=1 after release; new len=0 burst of 0x3C returns 0x3C.

Source files
------------

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer between a host command/TX/RX stream and a byte-wide SPI master.
// Runs one master byte transfer per TX byte, with a slave-select gap before each byte.
module spi_burst_ctrl #(
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_len,
    input  logic       cmd_cpol,
    input  logic       cmd_cpha,
    input  logic [7:0] cmd_br,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] m_data,
    output logic [7:0] m_spcon,
    output logic [7:0] m_spibr,
    output logic       m_spssn,
    input  logic [7:0] m_data_r,
    input  logic       m_finish
);

    localparam int unsigned LEN_W        = 4;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned GAP_W        = $clog2(GAP_CYC + 1);
    localparam int unsigned TMO_W        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned SPCON_EN_BIT = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_XFER,
        S_RXWAIT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [BYTE_W-1:0]   m_data_q, m_data_d;
    logic [BYTE_W-1:0]   m_spcon_q, m_spcon_d;
    logic [BYTE_W-1:0]   m_spibr_q, m_spibr_d;
    logic                m_spssn_q, m_spssn_d;
    logic                rx_valid_q, rx_valid_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    assign cmd_ready = (state_q == S_IDLE);
    assign tx_ready  = (state_q == S_FETCH);
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign m_data    = m_data_q;
    assign m_spcon   = m_spcon_q;
    assign m_spibr   = m_spibr_q;
    assign m_spssn   = m_spssn_q;

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;
        m_data_d    = m_data_q;
        m_spcon_d   = m_spcon_q;
        m_spibr_d   = m_spibr_q;
        m_spssn_d   = m_spssn_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    remaining_d = cmd_len;
                    m_spibr_d   = cmd_br;
                    m_spcon_d   = {1'b0, 1'b1, 3'b000, cmd_cpol, cmd_cpha, 1'b0};
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                m_spssn_d = 1'b1;
                if (tx_valid) begin
                    m_data_d = tx_data;
                    gap_d    = GAP_W'(GAP_CYC);
                    state_d  = S_SETUP;
                end
            end
            // Counter runs GAP_CYC..0 so select falls GAP_CYC+1 cycles after the TX handshake
            S_SETUP: begin
                m_spssn_d = 1'b1;
                if (gap_q == '0) begin
                    m_spssn_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = S_XFER;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_XFER: begin
                if (m_finish) begin
                    rx_data_d  = m_data_r;
                    rx_valid_d = 1'b1;
                    m_spssn_d  = 1'b1;
                    state_d    = S_RXWAIT;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    m_spssn_d = 1'b1;
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_RXWAIT: begin
                if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    if (remaining_q == '0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        remaining_d = remaining_q - LEN_W'(1);
                        state_d     = S_FETCH;
                    end
                end
            end
            // Only the enable drops; mode and baud stay so SCK idle level is held
            S_DONE: begin
                m_spcon_d[SPCON_EN_BIT] = 1'b0;
                busy_d                  = 1'b0;
                state_d                 = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            gap_q       <= '0;
            tmo_q       <= '0;
            m_data_q    <= '0;
            m_spcon_q   <= '0;
            m_spibr_q   <= '0;
            m_spssn_q   <= 1'b1;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            m_data_q    <= m_data_d;
            m_spcon_q   <= m_spcon_d;
            m_spibr_q   <= m_spibr_d;
            m_spssn_q   <= m_spssn_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl with a loopback SPI master model.
`timescale 1ns/1ps
module tb_spi_burst_ctrl;

    localparam int unsigned GAP_CYC = 4;
    localparam int unsigned TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_len;
    logic       cmd_cpol, cmd_cpha;
    logic [7:0] cmd_br;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] rx_data;
    logic       busy, done, err;
    logic [7:0] m_data, m_spcon, m_spibr;
    logic       m_spssn;
    logic [7:0] m_data_r;
    logic       m_finish;
    logic       mst_finish, spur_finish;

    assign m_finish = mst_finish | spur_finish;

    spi_burst_ctrl #(.GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha), .cmd_br(cmd_br),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .busy(busy), .done(done), .err(err),
        .m_data(m_data), .m_spcon(m_spcon), .m_spibr(m_spibr), .m_spssn(m_spssn),
        .m_data_r(m_data_r), .m_finish(m_finish)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_spcon = 8'h00;
    logic [7:0] cur_br = 8'h00;
    logic       master_dead = 1'b0;
    logic       hs_pending = 1'b0;
    int         hs_cyc = 0;
    int         ssn_falls = 0;
    int         last_fall = 0;
    int         last_rise = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    int         rx_valid_cycles = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: select edges, gap timing, done pulses, RX scoreboard, mode register while busy
    initial begin
        logic prev_ssn;
        prev_ssn = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            if (prev_ssn && !m_spssn) begin
                ssn_falls++;
                last_fall = cyc;
                if (hs_pending) begin
                    check_eq("gap_cycles", 32'(cyc - hs_cyc), 32'(GAP_CYC + 2));
                    hs_pending = 1'b0;
                end
            end
            if (!prev_ssn && m_spssn) last_rise = cyc;
            prev_ssn = m_spssn;
            if (done) done_cnt++;
            if (rx_valid) rx_valid_cycles++;
            if (rst_n && rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) check_eq("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
                else check_eq("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
            if (rst_n && busy) check_eq("m_spcon_busy", 32'(m_spcon), 32'(exp_spcon));
        end
    end

    // Master model: loops MOSI back to MISO after a baud-dependent latency
    initial begin
        logic [7:0] exp_b;
        int         lat;
        int         n;
        mst_finish = 1'b0;
        m_data_r   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && !m_spssn) begin
                exp_b = 8'h00;
                if (exp_tx.size() == 0) check_eq("tx_unexpected", 32'(m_data), 32'hFFFF_FFFF);
                else begin
                    exp_b = exp_tx.pop_front();
                    check_eq("m_data_at_ssn", 32'(m_data), 32'(exp_b));
                end
                lat = 8 + int'(cur_br[2:0]);
                n = 0;
                while (!m_spssn && n < 200) begin
                    if (!master_dead && n == lat) begin
                        m_data_r   = m_data;
                        mst_finish = 1'b1;
                    end
                    @(negedge clk);
                    mst_finish = 1'b0;
                    if (!m_spssn) check_eq("m_data_stable", 32'(m_data), 32'(exp_b));
                    n++;
                end
                if (n >= 200) check_eq("ssn_low_bound", 32'(n), 32'd0);
            end
        end
    end

    task automatic start_cmd(input logic [3:0] len, input logic cpol, input logic cpha,
                             input logic [7:0] br);
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_cpol  = cpol;
        cmd_cpha  = cpha;
        cmd_br    = br;
        cur_br    = br;
        exp_spcon = {1'b0, 1'b1, 3'b000, cpol, cpha, 1'b0};
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("busy_after_cmd", 32'(busy), 32'd1);
        check_eq("err_cleared", 32'(err), 32'd0);
        check_eq("m_spibr_cmd", 32'(m_spibr), 32'(br));
    endtask

    task automatic send_tx(input logic [7:0] b, input logic push_rx);
        int n;
        tx_valid = 1'b1;
        tx_data  = b;
        n = 0;
        while (!tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) check_eq("tx_ready_wait", 32'(tx_ready), 32'd1);
        else begin
            check_eq("ssn_high_fetch", 32'(m_spssn), 32'd1);
            hs_cyc     = cyc;
            hs_pending = 1'b1;
            exp_tx.push_back(b);
            if (push_rx) exp_rx.push_back(b);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("err_at_done", 32'(err), 32'(exp_err));
        exp_done++;
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("cmd_ready_after", 32'(cmd_ready), 32'd1);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("err_sticky", 32'(err), 32'(exp_err));
        check_eq("m_spcon_after", 32'(m_spcon), 32'(exp_spcon & 8'hBF));
        check_eq("m_spibr_after", 32'(m_spibr), 32'(cur_br));
        check_eq("ssn_idle", 32'(m_spssn), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int f0;
        int n;
        int rv0;
        int d0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_len     = 4'd0;
        cmd_cpol    = 1'b0;
        cmd_cpha    = 1'b0;
        cmd_br      = 8'h00;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        rx_ready    = 1'b1;
        spur_finish = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        check_eq("rst_m_spcon", 32'(m_spcon), 32'd0);
        check_eq("rst_m_spibr", 32'(m_spibr), 32'd0);
        check_eq("rst_m_spssn", 32'(m_spssn), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte, mode 0
        f0 = ssn_falls;
        start_cmd(4'd0, 1'b0, 1'b0, 8'h00);
        send_tx(8'hA5, 1'b1);
        wait_done(1'b0);
        check_eq("t1_windows", 32'(ssn_falls - f0), 32'd1);

        // Four bytes, mode 3
        f0 = ssn_falls;
        start_cmd(4'd3, 1'b1, 1'b1, 8'h12);
        for (int i = 1; i <= 4; i++) send_tx(8'(i), 1'b1);
        wait_done(1'b0);
        check_eq("t2_windows", 32'(ssn_falls - f0), 32'd4);

        // RX back-pressure holds the burst
        f0 = ssn_falls;
        rx_ready = 1'b0;
        start_cmd(4'd3, 1'b1, 1'b1, 8'h12);
        send_tx(8'h01, 1'b1);
        n = 0;
        while (!rx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("t3_rx_valid", 32'(rx_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("t3_hold_valid", 32'(rx_valid), 32'd1);
            check_eq("t3_hold_data", 32'(rx_data), 32'h01);
            check_eq("t3_hold_ssn", 32'(m_spssn), 32'd1);
            check_eq("t3_hold_txrdy", 32'(tx_ready), 32'd0);
        end
        check_eq("t3_one_window", 32'(ssn_falls - f0), 32'd1);
        rx_ready = 1'b1;
        for (int i = 2; i <= 4; i++) send_tx(8'(i), 1'b1);
        wait_done(1'b0);
        check_eq("t3_windows", 32'(ssn_falls - f0), 32'd4);

        // TX starvation holds FETCH; stray m_finish ignored
        f0 = ssn_falls;
        rv0 = rx_valid_cycles;
        start_cmd(4'd1, 1'b0, 1'b1, 8'h05);
        send_tx(8'hC3, 1'b1);
        n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        rv0 = rx_valid_cycles;
        for (int i = 0; i < 30; i++) begin
            spur_finish = (i == 10);
            @(negedge clk);
            check_eq("t4_ssn_high", 32'(m_spssn), 32'd1);
            check_eq("t4_busy", 32'(busy), 32'd1);
            check_eq("t4_fetch", 32'(tx_ready), 32'd1);
            check_eq("t4_no_rx", 32'(rx_valid), 32'd0);
        end
        spur_finish = 1'b0;
        send_tx(8'h5A, 1'b1);
        wait_done(1'b0);
        check_eq("t4_windows", 32'(ssn_falls - f0), 32'd2);

        // Finish timeout aborts the burst
        master_dead = 1'b1;
        f0 = ssn_falls;
        rv0 = rx_valid_cycles;
        start_cmd(4'd2, 1'b1, 1'b0, 8'h33);
        send_tx(8'h77, 1'b0);
        wait_done(1'b1);
        check_eq("t5_ssn_low_len", 32'(last_rise - last_fall), 32'(TIMEOUT));
        check_eq("t5_windows", 32'(ssn_falls - f0), 32'd1);
        repeat (5) @(negedge clk);
        check_eq("t5_no_rx", 32'(rx_valid_cycles - rv0), 32'd0);
        check_eq("t5_err_held", 32'(err), 32'd1);
        check_eq("t5_idle", 32'(cmd_ready), 32'd1);
        master_dead = 1'b0;

        // Reset during XFER of byte 2
        f0 = ssn_falls;
        start_cmd(4'd3, 1'b0, 1'b0, 8'h20);
        send_tx(8'h11, 1'b1);
        send_tx(8'h22, 1'b1);
        n = 0;
        while (ssn_falls < f0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq("t6_in_xfer", 32'(m_spssn), 32'd0);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("t6_ssn", 32'(m_spssn), 32'd1);
        check_eq("t6_spcon", 32'(m_spcon), 32'd0);
        check_eq("t6_spibr", 32'(m_spibr), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("t6_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("t6_m_data", 32'(m_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rx.delete();
        exp_tx.delete();
        hs_pending = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t6_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("t6_cmd_ready_rel", 32'(cmd_ready), 32'd1);
        start_cmd(4'd0, 1'b0, 1'b0, 8'h00);
        send_tx(8'h3C, 1'b1);
        wait_done(1'b0);

        repeat (5) @(negedge clk);
        check_eq("done_total", 32'(done_cnt), 32'(exp_done));
        check_eq("rx_queue_empty", 32'(exp_rx.size()), 32'd0);
        check_eq("tx_queue_empty", 32'(exp_tx.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
